video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Parametrised raster timing generator for the VGA/DAC output path. Successor to the fixed 640x480 timing block.
- Fully parametrised geometry, selectable sync polarity and a pixel clock-enable, so one 50 MHz `clk_vga` serves several modes.
- Adds line/frame strobes and a registered visible-area flag for downstream pixel pipelines (sprite/ball/paddle renderers, framebuffer readers).
- Single clock edge (posedge); all outputs registered.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_ACTIVE, 0, logic level of VGA_HS during sync pulse
- VS_ACTIVE, 0, logic level of VGA_VS during sync pulse
- X_W, 10, width of x output; must satisfy 2^X_W >= H_VISIBLE
- Y_W, 9, width of y output; must satisfy 2^Y_W >= V_VISIBLE

Ports:
- clk_vga  in  1  pixel/system clock, all logic on posedge
- rst  in  1  asynchronous active-high reset
- pix_ce  in  1  pixel clock enable; counters advance only when 1 (tie 1 for full-rate)
- VGA_HS  out  1  horizontal sync, polarity per HS_ACTIVE
- VGA_VS  out  1  vertical sync, polarity per VS_ACTIVE
- VGA_BLANK_N  out  1  1 inside visible area, else 0
- x  out  X_W  visible-area column, 0 outside visible
- y  out  Y_W  visible-area row, 0 outside visible
- line_start  out  1  one-cycle strobe at h_cnt==0
- frame_start  out  1  one-cycle strobe at h_cnt==0 && v_cnt==0
- vblank  out  1  1 while v_cnt outside visible lines

Behaviour:
- Derived constants:
  - H_TOTAL = H_SYNC+H_BACK+H_VISIBLE+H_FRONT
  - V_TOTAL likewise
  - H_START = H_SYNC+H_BACK
  - V_START = V_SYNC+V_BACK
- Counter widths are clog2(TOTAL), computed at elaboration.
- Phase order within a line and within a frame: sync, back porch, visible, front porch. Counter value 0 is the first sync cycle.
- Counters, on a posedge with pix_ce=1:
  - h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 when it is at V_TOTAL-1 and h_cnt wraps.
- pix_ce=0: counters hold; registered outputs keep their values.
- Output latency: every output is registered from the current counter state, so outputs reflect counter value c one clk_vga cycle after the counters hold c. All outputs share that same alignment, so x/y, BLANK_N and syncs are mutually aligned.
- Output decode:
  - VGA_HS = HS_ACTIVE when h_cnt < H_SYNC, else ~HS_ACTIVE.
  - VGA_VS = VS_ACTIVE when v_cnt < V_SYNC, else ~VS_ACTIVE.
  - h_vis = (H_START <= h_cnt < H_START+H_VISIBLE); v_vis likewise.
  - VGA_BLANK_N = h_vis && v_vis.
  - vblank = !v_vis.
  - x = h_vis&&v_vis ? h_cnt-H_START : 0, truncated to X_W. y likewise with V_START and Y_W.
- Strobes:
  - line_start = pix_ce && h_cnt==0.
  - frame_start = pix_ce && h_cnt==0 && v_cnt==0.
  - Each is high for exactly one clk_vga cycle per line/frame, including when pix_ce is divided.
- Reset (asynchronous, mid-frame allowed): counters go to 0 immediately.
  - VGA_HS = ~HS_ACTIVE, VGA_VS = ~VS_ACTIVE.
  - VGA_BLANK_N=0, x=0, y=0, line_start=0, frame_start=0, vblank=1.
- First posedge after reset release with pix_ce=1:
  - outputs show counter 0: HS/VS asserted, frame_start=1.
  - counters move to h_cnt=1.
- Illegal parameter set (any width 0, or 2^X_W < H_VISIBLE): elaboration error via generate-time check.

Optional Feature:
- Macro: VIDEO_TIMING_GEN_FRAME_CNT_EN.
- With the macro defined:
  - Extra output port frame_cnt[15:0].
  - Reset value 0.
  - Increments by 1 in the same cycle frame_start is registered high; wraps 65535 -> 0.
  - Intended for animation timing.
- Without the macro: port absent; no counter logic.

Test Plan:
1. Defaults, pix_ce=1, release reset:
   - VGA_HS low for exactly 96 cycles per 800-cycle line.
   - VGA_VS low for exactly 2 lines (1600 cycles) per 420000-cycle frame.
2. Defaults: first BLANK_N rise occurs at v_cnt=35, h_cnt=144 (+1 cycle latency) with x=0,y=0.
   - Last visible pixel shows x=639, y=479; next cycle BLANK_N=0, x=0, y=0.
3. pix_ce toggling 1/0 each cycle:
   - line period = 1600 clocks.
   - line_start high exactly 1 cycle per line.
   - outputs stable during pix_ce=0 cycles.
4. HS_ACTIVE=1, VS_ACTIVE=1, tiny mode H=4/1/2/1, V=3/1/1/1:
   - HS high for 2 of 8 cycles, VS high for 1 of 6 lines.
   - frame_start every 48 cycles.
5. Assert rst asynchronously mid-visible area (x=300, y=200):
   - outputs go to reset values without a clock edge.
   - after release, frame_start on first enabled edge.
6. With VIDEO_TIMING_GEN_FRAME_CNT_EN, tiny mode from 4:
   - frame_cnt=3 after 3 full frames.
   - wraps 65535->0 (force start near wrap via long run or reduced test mode).

Source files
------------

// File: rtl/video_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable and registered outputs.
// Optional frame counter output enabled by defining VIDEO_TIMING_GEN_FRAME_CNT_EN.
module video_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HS_ACTIVE = 0,
  parameter int VS_ACTIVE = 0,
  parameter int X_W       = 10,
  parameter int Y_W       = 9
) (
  input  logic           clk_vga,
  input  logic           rst,
  input  logic           pix_ce,
  output logic           VGA_HS,
  output logic           VGA_VS,
  output logic           VGA_BLANK_N,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           line_start,
  output logic           frame_start,
  output logic           vblank
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
  ,
  output logic [15:0]    frame_cnt
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;
  localparam int H_END   = H_START + H_VISIBLE;
  localparam int V_END   = V_START + V_VISIBLE;
  localparam int H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam logic HS_ON = HS_ACTIVE[0];
  localparam logic VS_ON = VS_ACTIVE[0];

  generate
    if (X_W < 1 || Y_W < 1 || H_TOTAL < 2 || V_TOTAL < 2 ||
        H_VISIBLE < 1 || V_VISIBLE < 1 ||
        (64'd1 << X_W) < 64'(H_VISIBLE) || (64'd1 << Y_W) < 64'(V_VISIBLE)) begin : g_bad_params
      $error("video_timing_gen: illegal geometry or output width parameters");
    end
  endgenerate

  logic [H_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_W-1:0] v_cnt_q, v_cnt_d;
  logic           hs_q, hs_d, vs_q, vs_d;
  logic           blank_n_q, blank_n_d, vblank_q, vblank_d;
  logic           line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           h_vis, v_vis;
  int             h_i, v_i;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
  logic [15:0]    frame_cnt_q, frame_cnt_d;
`endif

  // pix_ce qualifies every counter and level output; strobes are re-evaluated
  // each clk_vga cycle so they last exactly one cycle even with a divided pix_ce.
  always_comb begin
    h_i           = int'(h_cnt_q);
    v_i           = int'(v_cnt_q);
    h_vis         = (h_i >= H_START) && (h_i < H_END);
    v_vis         = (v_i >= V_START) && (v_i < V_END);
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    vblank_d      = vblank_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = pix_ce && (h_i == 0);
    frame_start_d = pix_ce && (h_i == 0) && (v_i == 0);
    if (pix_ce) begin
      if (h_i == H_TOTAL - 1) begin
        h_cnt_d = '0;
        v_cnt_d = (v_i == V_TOTAL - 1) ? '0 : v_cnt_q + V_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + H_W'(1);
      end
      hs_d      = (h_i < H_SYNC) ? HS_ON : ~HS_ON;
      vs_d      = (v_i < V_SYNC) ? VS_ON : ~VS_ON;
      blank_n_d = h_vis && v_vis;
      vblank_d  = !v_vis;
      x_d       = (h_vis && v_vis) ? X_W'(h_i - H_START) : '0;
      y_d       = (h_vis && v_vis) ? Y_W'(v_i - V_START) : '0;
    end
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
`endif
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hs_q          <= ~HS_ON;
      vs_q          <= ~VS_ON;
      blank_n_q     <= 1'b0;
      vblank_q      <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      vblank_q      <= vblank_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign vblank      = vblank_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
  assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default 640x480 instance plus a tiny active-high-sync
// instance, both checked every cycle against a position-arithmetic reference model.
module tb_video_timing_gen;

  logic clk_vga = 1'b0;
  logic rst;
  logic pix_ce;

  logic       hs_a, vs_a, bn_a, vb_a, ls_a, fs_a;
  logic [9:0] x_a;
  logic [8:0] y_a;
  logic       hs_b, vs_b, bn_b, vb_b, ls_b, fs_b;
  logic [1:0] x_b;
  logic [1:0] y_b;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
  logic [15:0] fc_a, fc_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Expected word: [63:48] frame count, [47:32] x, [31:16] y,
  // [5] hs, [4] vs, [3] blank_n, [2] vblank, [1] line_start, [0] frame_start
  logic [63:0] exp_a_q[$];
  logic [63:0] exp_b_q[$];

  int          mdl_n[2];
  int          mdl_fc[2];
  logic [63:0] mdl_last[2];
  int          ent_a = 0;
  bit          rise_armed = 1'b1;

  always #5 clk_vga = ~clk_vga;

  video_timing_gen u_dut_a (
    .clk_vga(clk_vga), .rst(rst), .pix_ce(pix_ce),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bn_a),
    .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a), .vblank(vb_a)
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  video_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_ACTIVE(1), .VS_ACTIVE(1), .X_W(2), .Y_W(2)
  ) u_dut_b (
    .clk_vga(clk_vga), .rst(rst), .pix_ce(pix_ce),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bn_b),
    .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b), .vblank(vb_b)
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Raster position -> outputs, from the phase order sync/back/visible/front.
  function automatic logic [63:0] decode(input int d, input int n);
    int hsy, hbp, hv, hfp, vsy, vbp, vv, vfp, ht, vt, h, v;
    bit hsa, vsa, hvis, vvis;
    logic [63:0] r;
    if (d == 0) begin
      hv = 640; hfp = 16; hsy = 96; hbp = 48; vv = 480; vfp = 10; vsy = 2; vbp = 33;
      hsa = 1'b0; vsa = 1'b0;
    end else begin
      hv = 4; hfp = 1; hsy = 2; hbp = 1; vv = 3; vfp = 1; vsy = 1; vbp = 1;
      hsa = 1'b1; vsa = 1'b1;
    end
    ht   = hsy + hbp + hv + hfp;
    vt   = vsy + vbp + vv + vfp;
    h    = n % ht;
    v    = (n / ht) % vt;
    hvis = (h >= hsy + hbp) && (h < hsy + hbp + hv);
    vvis = (v >= vsy + vbp) && (v < vsy + vbp + vv);
    r    = '0;
    r[5] = (h < hsy) ? hsa : !hsa;
    r[4] = (v < vsy) ? vsa : !vsa;
    r[3] = hvis && vvis;
    r[2] = !vvis;
    r[1] = (h == 0);
    r[0] = (h == 0) && (v == 0);
    if (hvis && vvis) begin
      r[47:32] = 16'(h - hsy - hbp);
      r[31:16] = 16'(v - vsy - vbp);
    end
    return r;
  endfunction

  function automatic logic [63:0] reset_vec(input int d);
    logic [63:0] r;
    r    = '0;
    r[5] = (d == 0) ? 1'b1 : 1'b0;
    r[4] = (d == 0) ? 1'b1 : 1'b0;
    r[2] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mdl_n[d]    = 0;
      mdl_fc[d]   = 0;
      mdl_last[d] = reset_vec(d);
    end
  endtask

  task automatic push_expected(input bit ce);
    logic [63:0] e;
    for (int d = 0; d < 2; d++) begin
      if (ce) begin
        e = decode(d, mdl_n[d]);
        mdl_n[d]++;
        if (e[0]) mdl_fc[d]++;
      end else begin
        e = mdl_last[d];
        e[1:0] = 2'b00;
      end
      e[63:48]    = 16'(mdl_fc[d]);
      mdl_last[d] = e;
      if (d == 0) exp_a_q.push_back(e);
      else        exp_b_q.push_back(e);
    end
  endtask

  task automatic compare_a(input logic [63:0] e);
    chk("a_hs", int'(hs_a), int'(e[5]));
    chk("a_vs", int'(vs_a), int'(e[4]));
    chk("a_blank_n", int'(bn_a), int'(e[3]));
    chk("a_vblank", int'(vb_a), int'(e[2]));
    chk("a_line_start", int'(ls_a), int'(e[1]));
    chk("a_frame_start", int'(fs_a), int'(e[0]));
    chk("a_x", int'(x_a), int'(e[47:32]));
    chk("a_y", int'(y_a), int'(e[31:16]));
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    chk("a_frame_cnt", int'(fc_a), int'(e[63:48]));
`endif
  endtask

  task automatic compare_b(input logic [63:0] e);
    chk("b_hs", int'(hs_b), int'(e[5]));
    chk("b_vs", int'(vs_b), int'(e[4]));
    chk("b_blank_n", int'(bn_b), int'(e[3]));
    chk("b_vblank", int'(vb_b), int'(e[2]));
    chk("b_line_start", int'(ls_b), int'(e[1]));
    chk("b_frame_start", int'(fs_b), int'(e[0]));
    chk("b_x", int'(x_b), int'(e[47:32]));
    chk("b_y", int'(y_b), int'(e[31:16]));
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    chk("b_frame_cnt", int'(fc_b), int'(e[63:48]));
`endif
  endtask

  // Monitor: one expected entry per clock edge, checked half a period later.
  always @(negedge clk_vga) begin
    if (!rst && exp_a_q.size() > 0) begin
      compare_a(exp_a_q.pop_front());
      ent_a++;
      if (rise_armed && bn_a) begin
        chk("a_first_blank_rise_edge", ent_a, 35 * 800 + 144 + 1);
        rise_armed = 1'b0;
      end
    end
    if (!rst && exp_b_q.size() > 0) begin
      compare_b(exp_b_q.pop_front());
    end
  end

  task automatic step(input bit ce);
    pix_ce = ce;
    @(posedge clk_vga);
    push_expected(ce);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_vga);
    #1;
    rst = 1'b1;
    #1;
    compare_a(reset_vec(0));
    compare_b(reset_vec(1));
    pix_ce = 1'b1;
    repeat (2) @(posedge clk_vga);
    #1;
    compare_a(reset_vec(0));
    compare_b(reset_vec(1));
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int guard;
    rst    = 1'b1;
    pix_ce = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_vga);
    #1;
    compare_a(reset_vec(0));
    compare_b(reset_vec(1));
    rst = 1'b0;

    // Full rate through the first visible line of the default mode.
    repeat (28400) step(1'b1);
    chk("a_blank_rise_seen", int'(rise_armed), 0);

    repeat (3000) step(1'(($urandom_range(0, 1))));
    for (int i = 0; i < 3200; i++) step((i % 2) == 0);

    // Asynchronous reset while the tiny instance is inside its visible area.
    guard = 0;
    do begin
      step(1'b1);
      guard++;
    end while (!mdl_last[1][3] && guard < 100);
    chk("b_reached_visible", int'(mdl_last[1][3]), 1);
    do_reset();
    repeat (2000) step($urandom_range(0, 3) != 0);

    repeat ($urandom_range(1, 200)) step(1'b1);
    do_reset();
    repeat (600) step(1'b1);

    @(negedge clk_vga);
    #1;
    chk("queue_a_drained", exp_a_q.size(), 0);
    chk("queue_b_drained", exp_b_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
